// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit (master) and the data memory
// or interconnect (slave). The bus uses a simple valid/ack handshake.
interface load_store_unit_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// Data-side load/store unit: checks size and alignment, runs one valid/ack bus
// access with byte lanes and a wait-state timeout, and returns extended load data.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic [1:0]        resp_err,
   load_store_unit_if.master bus
);

   // state | meaning
   // IDLE  | no access in flight; a valid request is decoded and accepted here
   // BUS   | bus_req high, waiting for bus_ack or the timeout
   // DONE  | one-cycle resp_valid; the core is released
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUS  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_ALIGN   = 2'b01;
   localparam logic [1:0] ERR_FUNCT3  = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state;
   logic [15:0] wait_cnt;
   logic [2:0]  funct3_q;
   logic [1:0]  lane_q;

   logic        funct3_legal;
   logic        misaligned;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic [31:0] lane_data;
   logic [31:0] load_data;

   assign stall      = req_valid && (state != DONE);
   assign resp_valid = (state == DONE);

   always_comb begin
      funct3_legal = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
         3'b100, 3'b101:         funct3_legal = !req_we;
         default:                funct3_legal = 1'b0;
      endcase

      misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

      case (req_funct3[1:0])
         2'b00: begin
            be_calc    = 4'b0001 << req_addr[1:0];
            wdata_calc = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be_calc    = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{req_wdata[15:0]}};
         end
         default: begin
            be_calc    = 4'b1111;
            wdata_calc = req_wdata;
         end
      endcase
   end

   // Read data is shifted down from the byte lane latched at accept time.
   always_comb begin
      lane_data = bus.bus_rdata >> {lane_q, 3'b000};
      case (funct3_q)
         3'b000:  load_data = {{24{lane_data[7]}}, lane_data[7:0]};
         3'b001:  load_data = {{16{lane_data[15]}}, lane_data[15:0]};
         3'b100:  load_data = {24'h000000, lane_data[7:0]};
         3'b101:  load_data = {16'h0000, lane_data[15:0]};
         default: load_data = bus.bus_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         wait_cnt      <= 16'h0000;
         funct3_q      <= 3'b000;
         lane_q        <= 2'b00;
         resp_rdata    <= 32'h0000_0000;
         resp_err      <= ERR_OK;
         bus.bus_req   <= 1'b0;
         bus.bus_we    <= 1'b0;
         bus.bus_addr  <= 32'h0000_0000;
         bus.bus_wdata <= 32'h0000_0000;
         bus.bus_be    <= 4'b0000;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  funct3_q <= req_funct3;
                  lane_q   <= req_addr[1:0];
                  if (!funct3_legal) begin
                     state      <= DONE;
                     resp_err   <= ERR_FUNCT3;
                     resp_rdata <= 32'h0000_0000;
                  end else if (misaligned) begin
                     state      <= DONE;
                     resp_err   <= ERR_ALIGN;
                     resp_rdata <= 32'h0000_0000;
                  end else begin
                     state         <= BUS;
                     wait_cnt      <= 16'h0000;
                     bus.bus_req   <= 1'b1;
                     bus.bus_we    <= req_we;
                     bus.bus_addr  <= {req_addr[31:2], 2'b00};
                     bus.bus_be    <= be_calc;
                     bus.bus_wdata <= wdata_calc;
                  end
               end
            end
            BUS: begin
               // An ack in the expiry cycle still completes the access normally.
               if (bus.bus_ack) begin
                  state       <= DONE;
                  bus.bus_req <= 1'b0;
                  resp_err    <= ERR_OK;
                  resp_rdata  <= bus.bus_we ? 32'h0000_0000 : load_data;
               end else if (wait_cnt == CNT_LAST) begin
                  state       <= DONE;
                  bus.bus_req <= 1'b0;
                  resp_err    <= ERR_TIMEOUT;
                  resp_rdata  <= 32'h0000_0000;
               end else begin
                  wait_cnt <= wait_cnt + 16'h0001;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: a byte-level reference model
// predicts each response, and a monitor checks responses and bus fields.
module tb_load_store_unit;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;

   load_store_unit_if bus ();

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rdata;
      logic [1:0]  err;
   } resp_t;

   resp_t       exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   int          ack_delay = -1;
   logic [31:0] mem_rdata = 32'h0;
   int          bus_cyc = 0;
   logic        exp_we = 1'b0;
   logic [3:0]  exp_be = 4'h0;
   logic [31:0] exp_addr = 32'h0;
   logic [31:0] exp_wdata = 32'h0;

   function automatic void check(input string name, input logic [95:0] act, input logic [95:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
      end
   endfunction

   // Reference model: byte lists and integer arithmetic, no lane tables.
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata, input int delay,
                                 output resp_t r, output logic [3:0] be, output logic [31:0] wd,
                                 output int lat, output int nbus);
      int     nbytes;
      int     off;
      logic   legal;
      longint v;
      off = int'(addr % 4);
      case (int'(f3) % 4)
         0:       nbytes = 1;
         1:       nbytes = 2;
         2:       nbytes = 4;
         default: nbytes = 0;
      endcase
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      be = 4'h0;
      wd = 32'h0;
      r.rdata = 32'h0;
      if (nbytes > 0) begin
         for (int i = 0; i < nbytes; i++) be[(off + i) % 4] = 1'b1;
         for (int j = 0; j < 4; j++) wd[8*j +: 8] = wdata[8*(j % nbytes) +: 8];
      end
      if (!legal) begin
         r.err = 2'b10; lat = 1; nbus = 0;
      end else if (off % nbytes != 0) begin
         r.err = 2'b01; lat = 1; nbus = 0;
      end else if (delay < 0 || delay >= TO) begin
         r.err = 2'b11; lat = TO + 1; nbus = TO;
      end else begin
         r.err = 2'b00; lat = delay + 2; nbus = delay + 1;
         if (!we) begin
            v = 0;
            for (int i = 0; i < nbytes; i++) v += longint'(rdata[8*(off + i) +: 8]) << (8 * i);
            if (f3 < 3'd4 && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
               v -= longint'(1) << (8 * nbytes);
            r.rdata = v[31:0];
         end
      end
   endfunction

   // Memory side: acks after ack_delay wait cycles, random ack noise while idle.
   always @(posedge clk) begin
      #1;
      if (bus.bus_req) begin
         bus_cyc++;
         bus.bus_ack   = (ack_delay >= 0) && (bus_cyc == ack_delay + 1);
         bus.bus_rdata = bus.bus_ack ? mem_rdata : $urandom;
      end else begin
         bus_cyc       = 0;
         bus.bus_ack   = 1'($urandom_range(0, 1));
         bus.bus_rdata = $urandom;
      end
   end

   always @(negedge clk) begin
      resp_t e;
      if (reset && resp_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_resp: got resp_valid with err %0d, want none", resp_err);
         end else begin
            e = exp_q.pop_front();
            check("resp_err", 96'(resp_err), 96'(e.err));
            if (e.err == 2'b00 || e.err == 2'b11) check("resp_rdata", 96'(resp_rdata), 96'(e.rdata));
         end
      end
      if (reset && bus.bus_req)
         check("bus_fields",
               {27'h0, bus.bus_we, bus.bus_be, bus.bus_addr, bus.bus_we ? bus.bus_wdata : 32'h0},
               {27'h0, exp_we, exp_be, exp_addr, exp_we ? exp_wdata : 32'h0});
   end

   // Called at posedge+1 with the DUT idle; returns at posedge+1 after the response.
   task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
      resp_t r;
      int    lat;
      int    nbus;
      int    cyc;
      int    nreq;
      logic  seen;
      model(we, f3, addr, wdata, rdata, delay, r, exp_be, exp_wdata, lat, nbus);
      exp_we    = we;
      exp_addr  = {addr[31:2], 2'b00};
      ack_delay = delay;
      mem_rdata = rdata;
      exp_q.push_back(r);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      cyc  = 0;
      nreq = 0;
      seen = 1'b0;
      while (!seen && cyc < TO + 10) begin
         @(negedge clk);
         cyc++;
         if (bus.bus_req) nreq++;
         if (resp_valid) begin
            seen = 1'b1;
            check("latency", 96'(cyc - 1), 96'(lat));
            check("stall_done", 96'(stall), 96'(1'b0));
         end else begin
            check("stall_busy", 96'(stall), 96'(1'b1));
         end
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL resp_wait: got no resp_valid in %0d cycles, want one", cyc);
      end
      check("bus_req_cycles", 96'(nreq), 96'(nbus));
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int d;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      #12;
      check("rst_outputs",
            {bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_wdata, bus.bus_be, resp_valid, resp_rdata, resp_err},
            96'h0);
      check("rst_stall_hi", 96'(stall), 96'(1'b1));
      req_valid = 1'b0;
      #1;
      check("rst_stall_lo", 96'(stall), 96'(1'b0));
      @(posedge clk);
      #1;
      reset = 1'b1;
      gap(2);

      access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
      access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
      access(1'b0, 3'b000, 32'h3, 32'h0, 32'h80F07F81, 0);
      access(1'b0, 3'b100, 32'h3, 32'h0, 32'h80F07F81, 1);
      access(1'b0, 3'b001, 32'h2, 32'h0, 32'h80F07F81, 0);
      access(1'b0, 3'b101, 32'h0, 32'h0, 32'h80F07F81, 2);
      access(1'b1, 3'b000, 32'h1, 32'h000000AB, 32'h0, 0);
      access(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
      access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
      access(1'b1, 3'b001, 32'h1, 32'h1234, 32'h0, 0);
      access(1'b0, 3'b010, 32'h40, 32'h0, 32'h13579BDF, 5);
      access(1'b0, 3'b010, 32'h44, 32'h0, 32'h2468ACE0, -1);
      access(1'b0, 3'b010, 32'h48, 32'h0, 32'hCAFEF00D, TO - 1);
      access(1'b1, 3'b010, 32'h4C, 32'h5A5A5A5A, 32'h0, TO);

      // Reset in the middle of a bus access: no response, bus_req drops at once.
      exp_we    = 1'b0;
      exp_addr  = 32'h200;
      exp_be    = 4'hF;
      ack_delay = -1;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h200;
      gap(3);
      #1;
      check("midbus_req_before", 96'(bus.bus_req), 96'(1'b1));
      reset = 1'b0;
      #1;
      check("midbus_req_after", 96'(bus.bus_req), 96'(1'b0));
      check("midbus_resp", 96'(resp_valid), 96'(1'b0));
      req_valid = 1'b0;
      gap(2);
      reset = 1'b1;
      gap(3);
      access(1'b0, 3'b010, 32'h200, 32'h0, 32'h0BADCAFE, 1);

      for (int n = 0; n < 300; n++) begin
         d = int'($urandom_range(0, 10)) - 1;
         access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, d);
         gap(int'($urandom_range(0, 2)));
      end

      gap(4);
      check("queue_drained", 96'(exp_q.size()), 96'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
